// File: rtl/pipe_reg_if_id_skid.sv
// IF->D pipeline register with a two-entry skid buffer (main + skid).
// Entries carry the instruction, its PC, fetch exception code, delay-slot
// flag and the T_use pre-decode, all computed once at capture time.
// in_ready depends only on registered skid occupancy, so there is no
// combinational path from out_ready back to in_ready.
module pipe_reg_if_id_skid #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 5,
  parameter int T_W    = 5,
  parameter int NO_USE = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_pc_plus_4,
  output logic [DATA_W-1:0] out_pc_plus_8,
  output logic [T_W-1:0]    out_t_use_rs,
  output logic [T_W-1:0]    out_t_use_rt,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd
);

  // Entry layout: {instr, pc, exc, bd, t_use_rs, t_use_rt}
  localparam int E_W = 2*DATA_W + EXC_W + 1 + 2*T_W;

  localparam logic [T_W-1:0] T_NU = T_W'(NO_USE);
  localparam logic [T_W-1:0] T_0  = T_W'(0);
  localparam logic [T_W-1:0] T_1  = T_W'(1);
  localparam logic [T_W-1:0] T_2  = T_W'(2);

  logic             r_main_v;
  logic             r_skid_v;
  logic [E_W-1:0]   r_main;
  logic [E_W-1:0]   r_skid;

  logic [5:0]       w_op;
  logic [5:0]       w_funct;
  logic [4:0]       w_rs_f;
  logic [4:0]       w_rt_f;
  logic [T_W-1:0]   w_trs;
  logic [T_W-1:0]   w_trt;
  logic [E_W-1:0]   w_in_entry;
  logic             w_acc;
  logic             w_take;

  assign w_op    = in_instr[31:26];
  assign w_funct = in_instr[5:0];
  assign w_rs_f  = in_instr[25:21];
  assign w_rt_f  = in_instr[20:16];

  // T_use pre-decode of the incoming instruction word
  always_comb begin
    w_trs = T_NU;
    w_trt = T_NU;
    case (w_op)
      6'h00: begin
        case (w_funct)
          6'h08, 6'h09: w_trs = T_0;                      // jr, jalr
          6'h11, 6'h13: w_trs = T_1;                      // mthi, mtlo
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b, 6'h04, 6'h06, 6'h07,
          6'h18, 6'h19, 6'h1a, 6'h1b: begin
            w_trs = T_1;
            w_trt = T_1;
          end
          6'h00: if (in_instr != '0) w_trt = T_1;         // sll, but not nop
          6'h02, 6'h03: w_trt = T_1;                      // srl, sra
          default: ;
        endcase
      end
      6'h01: begin                                        // bltz / bgez
        if (w_rt_f == 5'd0 || w_rt_f == 5'd1) begin
          w_trs = T_0;
          w_trt = T_0;
        end
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin                   // beq bne blez bgtz
        w_trs = T_0;
        w_trt = T_0;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e,    // ALU immediate (not lui)
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25:                  // loads
        w_trs = T_1;
      6'h28, 6'h29, 6'h2b: begin                          // stores
        w_trs = T_1;
        w_trt = T_2;
      end
      6'h10: if (w_rs_f == 5'd4) w_trt = T_1;             // mtc0
      default: ;
    endcase
  end

  // Build the stored entry; a fetch exception squashes the word but keeps it valid
  always_comb begin
    if (in_exc != '0)
      w_in_entry = {{DATA_W{1'b0}}, in_pc, in_exc, in_bd, T_NU, T_NU};
    else
      w_in_entry = {in_instr, in_pc, in_exc, in_bd, w_trs, w_trt};
  end

  assign in_ready = !r_skid_v;
  assign w_acc    = in_valid && in_ready;
  assign w_take   = r_main_v && out_ready;

  // Main/skid occupancy and payload; skid only fills when main is stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= '0;
      r_skid   <= '0;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else begin
      if (!r_main_v || w_take) begin
        if (r_skid_v) begin
          r_main   <= r_skid;
          r_main_v <= 1'b1;
          r_skid_v <= 1'b0;
        end else if (w_acc) begin
          r_main   <= w_in_entry;
          r_main_v <= 1'b1;
        end else begin
          r_main_v <= 1'b0;
        end
      end else if (w_acc) begin
        r_skid   <= w_in_entry;
        r_skid_v <= 1'b1;
      end
    end
  end

  assign out_valid     = r_main_v;
  assign out_instr     = r_main_v ? r_main[E_W-1 -: DATA_W]               : '0;
  assign out_pc        = r_main_v ? r_main[E_W-DATA_W-1 -: DATA_W]        : '0;
  assign out_exc       = r_main_v ? r_main[2*T_W+1 +: EXC_W]              : '0;
  assign out_bd        = r_main_v ? r_main[2*T_W]                         : 1'b0;
  assign out_t_use_rs  = r_main_v ? r_main[T_W +: T_W]                    : T_NU;
  assign out_t_use_rt  = r_main_v ? r_main[0 +: T_W]                      : T_NU;
  assign out_pc_plus_4 = out_pc + DATA_W'(4);
  assign out_pc_plus_8 = out_pc + DATA_W'(8);

endmodule

// File: tb/tb_pipe_reg_if_id_skid.sv
// Directed bench for pipe_reg_if_id_skid. Inputs change 1 time unit after a
// rising edge; outputs are checked in that same window.
module tb_pipe_reg_if_id_skid;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  in_exc;
  logic        in_bd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [31:0] out_pc_plus_8;
  logic [4:0]  out_t_use_rs;
  logic [4:0]  out_t_use_rt;
  logic [4:0]  out_exc;
  logic        out_bd;

  int checks;
  int failures;

  pipe_reg_if_id_skid dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus_4(out_pc_plus_4), .out_pc_plus_8(out_pc_plus_8),
    .out_t_use_rs(out_t_use_rs), .out_t_use_rt(out_t_use_rt),
    .out_exc(out_exc), .out_bd(out_bd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
    in_exc   = 5'd0;
    in_bd    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || out_pc !== 32'h0 ||
        out_exc !== 5'd0 || out_bd !== 1'b0 || out_t_use_rs !== 5'd31 || out_t_use_rt !== 5'd31) begin
      failures++;
      $display("FAIL reset_state: v=%0b rdy=%0b instr=%h pc=%h exc=%0d bd=%0b t=%0d/%0d want 0 1 0 0 0 0 31/31",
               out_valid, in_ready, out_instr, out_pc, out_exc, out_bd, out_t_use_rs, out_t_use_rt);
    end
    #3 reset = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [4];
    logic [4:0]  ers [4];
    logic [4:0]  ert [4];
    instrs[0] = 32'h00221821; ers[0] = 5'd1;  ert[0] = 5'd1;   // addu
    instrs[1] = 32'hAC220004; ers[1] = 5'd1;  ert[1] = 5'd2;   // sw
    instrs[2] = 32'h10220004; ers[2] = 5'd0;  ert[2] = 5'd0;   // beq
    instrs[3] = 32'h3C011234; ers[3] = 5'd31; ert[3] = 5'd31;  // lui
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, instrs[i], 32'h3000 + 32'(4*i));
      step();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== instrs[i] || out_pc !== 32'h3000 + 32'(4*i) ||
          out_t_use_rs !== ers[i] || out_t_use_rt !== ert[i] ||
          out_pc_plus_8 !== 32'h3008 + 32'(4*i) || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_%0d: v=%0b instr=%h pc=%h t=%0d/%0d pc8=%h rdy=%0b want instr=%h t=%0d/%0d",
                 i, out_valid, out_instr, out_pc, out_t_use_rs, out_t_use_rt, out_pc_plus_8,
                 in_ready, instrs[i], ers[i], ert[i]);
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h00000AAA, 32'h5000);      // A
    step();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00000AAA || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first: v=%0b instr=%h rdy=%0b want 1 00000aaa 1", out_valid, out_instr, in_ready);
    end
    drive(1'b1, 32'h00000BBB, 32'h5004);      // B -> skid
    step();
    checks++;
    if (in_ready !== 1'b0 || out_instr !== 32'h00000AAA) begin
      failures++;
      $display("FAIL bp_skid_full: rdy=%0b instr=%h want 0 00000aaa", in_ready, out_instr);
    end
    drive(1'b1, 32'h00000CCC, 32'h5008);      // C held off
    step();
    checks++;
    if (in_ready !== 1'b0 || out_instr !== 32'h00000AAA || out_pc !== 32'h5000) begin
      failures++;
      $display("FAIL bp_hold: rdy=%0b instr=%h pc=%h want 0 00000aaa 5000", in_ready, out_instr, out_pc);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00000BBB || out_pc !== 32'h5004 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain_b: v=%0b instr=%h pc=%h rdy=%0b want 1 00000bbb 5004 1",
               out_valid, out_instr, out_pc, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00000CCC || out_pc !== 32'h5008) begin
      failures++;
      $display("FAIL bp_drain_c: v=%0b instr=%h pc=%h want 1 00000ccc 5008", out_valid, out_instr, out_pc);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_dup: out_valid=%0b instr=%h want 0", out_valid, out_instr);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h00000111, 32'h6000);
    step();
    drive(1'b1, 32'h00000222, 32'h6004);
    step();
    drive(1'b1, 32'h00000333, 32'h6008);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0) begin
      failures++;
      $display("FAIL flush_full: v=%0b rdy=%0b instr=%h want 0 1 0", out_valid, in_ready, out_instr);
    end
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_ghost: v=%0b instr=%h want 0", out_valid, out_instr);
    end
    // Flush while main holds an entry and a transfer is accepted: transfer dropped
    out_ready = 1'b0;
    drive(1'b1, 32'h00000444, 32'h6010);
    step();
    drive(1'b1, 32'h00000555, 32'h6014);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_drop_acc: v=%0b rdy=%0b instr=%h want 0 1", out_valid, in_ready, out_instr);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_drop_later: v=%0b instr=%h want 0", out_valid, out_instr);
    end
  endtask

  task automatic test_exception();
    out_ready = 1'b1;
    drive(1'b1, 32'h8C010000, 32'h4000);
    in_exc = 5'd4;
    in_bd  = 1'b1;
    step();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0 || out_exc !== 5'd4 || out_bd !== 1'b1 ||
        out_pc !== 32'h4000 || out_t_use_rs !== 5'd31 || out_t_use_rt !== 5'd31) begin
      failures++;
      $display("FAIL exc_squash: v=%0b instr=%h exc=%0d bd=%0b pc=%h t=%0d/%0d want 1 0 4 1 4000 31/31",
               out_valid, out_instr, out_exc, out_bd, out_pc, out_t_use_rs, out_t_use_rt);
    end
    step();
  endtask

  task automatic test_pc_wrap();
    out_ready = 1'b1;
    drive(1'b1, 32'h00000000, 32'hFFFFFFF8);
    step();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (out_pc_plus_4 !== 32'hFFFFFFFC || out_pc_plus_8 !== 32'h00000000) begin
      failures++;
      $display("FAIL pc_wrap: pc4=%h pc8=%h want fffffffc 00000000", out_pc_plus_4, out_pc_plus_8);
    end
    step();
  endtask

  task automatic test_tuse_table();
    logic [31:0] ins [11];
    logic [4:0]  ers [11];
    logic [4:0]  ert [11];
    ins[0]  = 32'h03E00008; ers[0]  = 5'd0;  ert[0]  = 5'd31;  // jr
    ins[1]  = 32'h00020880; ers[1]  = 5'd31; ert[1]  = 5'd1;   // sll
    ins[2]  = 32'h00000000; ers[2]  = 5'd31; ert[2]  = 5'd31;  // nop
    ins[3]  = 32'h40816000; ers[3]  = 5'd31; ert[3]  = 5'd1;   // mtc0
    ins[4]  = 32'h00200011; ers[4]  = 5'd1;  ert[4]  = 5'd31;  // mthi
    ins[5]  = 32'h24210001; ers[5]  = 5'd1;  ert[5]  = 5'd31;  // addiu
    ins[6]  = 32'h04210004; ers[6]  = 5'd0;  ert[6]  = 5'd0;   // bgez
    ins[7]  = 32'h00220018; ers[7]  = 5'd1;  ert[7]  = 5'd1;   // mult
    ins[8]  = 32'h0C000000; ers[8]  = 5'd31; ert[8]  = 5'd31;  // jal
    ins[9]  = 32'h40016000; ers[9]  = 5'd31; ert[9]  = 5'd31;  // mfc0
    ins[10] = 32'h42000018; ers[10] = 5'd31; ert[10] = 5'd31;  // eret
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, ins[i], 32'h7000 + 32'(4*i));
      step();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== ins[i] || out_t_use_rs !== ers[i] || out_t_use_rt !== ert[i]) begin
        failures++;
        $display("FAIL tuse_%0d: instr=%h t=%0d/%0d want %h t=%0d/%0d",
                 i, out_instr, out_t_use_rs, out_t_use_rt, ins[i], ers[i], ert[i]);
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h00221821, 32'h8000);
    step();
    drive(1'b1, 32'hAC220004, 32'h8004);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL areset_setup: rdy=%0b v=%0b want 0 1", in_ready, out_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_t_use_rs !== 5'd31 ||
        out_t_use_rt !== 5'd31 || out_instr !== 32'h0) begin
      failures++;
      $display("FAIL areset_immediate: v=%0b rdy=%0b t=%0d/%0d instr=%h want 0 1 31/31 0",
               out_valid, in_ready, out_t_use_rs, out_t_use_rt, out_instr);
    end
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    #2 reset = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL areset_after: v=%0b rdy=%0b want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_exception();
    test_pc_wrap();
    test_tuse_table();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
